// File: rtl/adder_pkg.sv
// Shared widths, carry-segment bounds and word type for the hybrid 8-bit adder.
// Latency: none (declarations only).
// Backpressure: not applicable.
package adder_pkg;

    localparam int ADDER_W = 8;

    // Carry-chain segment bounds, LSB first: ripple [1:0], lookahead [4:2], ripple [7:5]
    localparam int RC0_LSB = 0;
    localparam int CLA_LSB = 2;
    localparam int RC2_LSB = 5;

    localparam int RC0_W = CLA_LSB - RC0_LSB;
    localparam int CLA_W = RC2_LSB - CLA_LSB;
    localparam int RC2_W = ADDER_W - RC2_LSB;

    typedef logic [ADDER_W-1:0] word_t;

endpackage

// File: rtl/adder_main_cla3_block.sv
// 3-bit carry-lookahead segment: every carry is a flat sum of products of cin.
// Latency: purely combinational.
// Backpressure: not applicable.
module cla3_block (
    input  logic [2:0] p,
    input  logic [2:0] g,
    input  logic       cin,
    output logic [3:1] c,
    output logic [2:0] s
);

    // Each carry is computed directly from cin, not rippled from the previous bit
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);

    assign s[0] = p[0] ^ cin;
    assign s[1] = p[1] ^ c[1];
    assign s[2] = p[2] ^ c[2];

endmodule

// File: rtl/adder_main.sv
// Registered 8-bit hybrid adder {c8,s} = x + y + c0 (ripple 2 / lookahead 3 / ripple 3); ADDER_OVF_EN adds ovf.
// Latency: 1 cycle from an in_valid edge to s/c8/out_valid.
// Backpressure: none; every in_valid cycle is accepted, results hold while in_valid is low.
module adder_main
    import adder_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic       c0,
    output logic [7:0] s,
    output logic       c8,
    output logic       out_valid
`ifdef ADDER_OVF_EN
    ,
    output logic       ovf
`endif
);

    word_t              p;
    word_t              g;
    word_t              core_sum;

    logic [RC0_W:0]     rc0_c;      // rc0_c[0] = c0, rc0_c[2] = c2
    logic [RC0_W-1:0]   rc0_sum;
    logic [CLA_W:1]     cla_c;      // c3..c5
    logic [CLA_W-1:0]   cla_sum;
    logic [RC2_W:0]     rc2_c;      // rc2_c[0] = c5, rc2_c[2] = c7, rc2_c[3] = c8
    logic [RC2_W-1:0]   rc2_sum;

    assign p = x ^ y;
    assign g = x & y;

    // Low ripple segment: full adders on bits 1:0 starting from c0
    always_comb begin
        rc0_c    = '0;
        rc0_sum  = '0;
        rc0_c[0] = c0;
        for (int i = 0; i < RC0_W; i++) begin
            rc0_sum[i]  = p[RC0_LSB+i] ^ rc0_c[i];
            rc0_c[i+1]  = g[RC0_LSB+i] | (p[RC0_LSB+i] & rc0_c[i]);
        end
    end

    cla3_block u_cla (
        .p   (p[CLA_LSB +: CLA_W]),
        .g   (g[CLA_LSB +: CLA_W]),
        .cin (rc0_c[RC0_W]),
        .c   (cla_c),
        .s   (cla_sum)
    );

    // High ripple segment: full adders on bits 7:5 starting from the lookahead carry c5
    always_comb begin
        rc2_c    = '0;
        rc2_sum  = '0;
        rc2_c[0] = cla_c[CLA_W];
        for (int i = 0; i < RC2_W; i++) begin
            rc2_sum[i]  = p[RC2_LSB+i] ^ rc2_c[i];
            rc2_c[i+1]  = g[RC2_LSB+i] | (p[RC2_LSB+i] & rc2_c[i]);
        end
    end

    assign core_sum = {rc2_sum, cla_sum, rc0_sum};

    // Result register: load on in_valid, otherwise hold; out_valid marks a fresh load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s         <= '0;
            c8        <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                s  <= core_sum;
                c8 <= rc2_c[RC2_W];
            end
        end
    end

`ifdef ADDER_OVF_EN
    // Signed overflow: carry into the sign bit differs from carry out of it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (in_valid) begin
            ovf <= rc2_c[RC2_W-1] ^ rc2_c[RC2_W];
        end
    end
`endif

endmodule

// File: tb/tb_adder_main.sv
// Self-checking bench for adder_main against a plain-arithmetic reference model.
// Covers reset, directed vectors and boundaries, hold, random streams and an x/y sweep.
module tb_adder_main;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] x;
    logic [7:0] y;
    logic       c0;
    logic [7:0] s;
    logic       c8;
    logic       out_valid;
`ifdef ADDER_OVF_EN
    logic       ovf;
`endif

    int checks   = 0;
    int failures = 0;

    adder_main dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .x         (x),
        .y         (y),
        .c0        (c0),
        .s         (s),
        .c8        (c8),
        .out_valid (out_valid)
`ifdef ADDER_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: 9-bit integer sum
    function automatic logic [8:0] ref_sum(input logic [7:0] a, input logic [7:0] b, input logic ci);
        int unsigned t;
        t = int'(a) + int'(b) + int'(ci);
        return t[8:0];
    endfunction

    // Reference: signed overflow from the sign rule (same-sign operands, different-sign result)
    function automatic logic ref_ovf(input logic [7:0] a, input logic [7:0] b, input logic ci);
        int sa, sb, t;
        sa = int'($signed(a));
        sb = int'($signed(b));
        t  = sa + sb + int'(ci);
        return (t > 127) || (t < -128);
    endfunction

    // Drive one operand set and advance past the next rising edge
    task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b, input logic ci);
        in_valid = v;
        x        = a;
        y        = b;
        c0       = ci;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        x = 8'h00; y = 8'h00; c0 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({c8, s, out_valid} !== 10'b0) begin
            failures++;
            $display("FAIL reset_init got c8=%b s=%h vld=%b want 0/00/0", c8, s, out_valid);
        end
        rst_n = 1'b1;
        // Load a nonzero result, then assert reset between edges
        step(1'b1, 8'hFF, 8'hFF, 1'b1);
        checks++;
        if ({c8, s, out_valid} !== {1'b1, 8'hFF, 1'b1}) begin
            failures++;
            $display("FAIL reset_preload got c8=%b s=%h vld=%b want 1/ff/1", c8, s, out_valid);
        end
        in_valid = 1'b1;
        x = 8'h12; y = 8'h34; c0 = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({c8, s, out_valid} !== 10'b0) begin
            failures++;
            $display("FAIL reset_async got c8=%b s=%h vld=%b want 0/00/0", c8, s, out_valid);
        end
        // Pending operands while in reset must not load
        @(posedge clk);
        #1;
        checks++;
        if ({c8, s, out_valid} !== 10'b0) begin
            failures++;
            $display("FAIL reset_hold got c8=%b s=%h vld=%b want 0/00/0", c8, s, out_valid);
        end
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 8'h12, 8'h34, 1'b0);
        checks++;
        if (out_valid !== 1'b0 || s !== 8'h00) begin
            failures++;
            $display("FAIL reset_release_idle got s=%h vld=%b want 00/0", s, out_valid);
        end
        step(1'b1, 8'h12, 8'h34, 1'b0);
        checks++;
        if ({c8, s, out_valid} !== {1'b0, 8'h46, 1'b1}) begin
            failures++;
            $display("FAIL reset_first_result got c8=%b s=%h vld=%b want 0/46/1", c8, s, out_valid);
        end
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic [7:0] es;
        logic       ec8;
        logic       eovf;
    } vec_t;

    task automatic test_directed();
        vec_t v [11];
        v[0]  = '{8'h60, 8'h7F, 1'b0, 8'hDF, 1'b0, 1'b1};
        v[1]  = '{8'h01, 8'h00, 1'b0, 8'h01, 1'b0, 1'b0};
        v[2]  = '{8'hFF, 8'hFE, 1'b0, 8'hFD, 1'b1, 1'b0};
        v[3]  = '{8'hF0, 8'h88, 1'b0, 8'h78, 1'b1, 1'b1};
        v[4]  = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0};
        v[5]  = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0};
        v[6]  = '{8'h08, 8'h81, 1'b0, 8'h89, 1'b0, 1'b0};
        v[7]  = '{8'h08, 8'h81, 1'b1, 8'h8A, 1'b0, 1'b0};
        v[8]  = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        v[9]  = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        v[10] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
        for (int i = 0; i < 11; i++) begin
            step(1'b1, v[i].a, v[i].b, v[i].ci);
            checks++;
            if ({c8, s, out_valid} !== {v[i].ec8, v[i].es, 1'b1}) begin
                failures++;
                $display("FAIL directed[%0d] %h+%h+%b got c8=%b s=%h vld=%b want %b/%h/1",
                         i, v[i].a, v[i].b, v[i].ci, c8, s, out_valid, v[i].ec8, v[i].es);
            end
`ifdef ADDER_OVF_EN
            checks++;
            if (ovf !== v[i].eovf) begin
                failures++;
                $display("FAIL directed_ovf[%0d] got %b want %b", i, ovf, v[i].eovf);
            end
`endif
        end
    endtask

    task automatic test_hold();
        logic [7:0] hs;
        logic       hc;
        step(1'b1, 8'h3C, 8'h5A, 1'b1);
        hs = 8'h97;
        hc = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
            checks++;
            if ({c8, s, out_valid} !== {hc, hs, 1'b0}) begin
                failures++;
                $display("FAIL hold[%0d] got c8=%b s=%h vld=%b want %b/%h/0", i, c8, s, out_valid, hc, hs);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] exp_r;
        logic       exp_o;
        logic       v;
        logic [7:0] a, b;
        logic       ci;
        exp_r = ref_sum(8'h3C, 8'h5A, 1'b1);
        exp_o = ref_ovf(8'h3C, 8'h5A, 1'b1);
        for (int i = 0; i < 2000; i++) begin
            v  = ($urandom_range(0, 3) != 0);
            a  = 8'($urandom);
            b  = 8'($urandom);
            ci = 1'($urandom);
            step(v, a, b, ci);
            if (v) begin
                exp_r = ref_sum(a, b, ci);
                exp_o = ref_ovf(a, b, ci);
            end
            checks++;
            if ({c8, s, out_valid} !== {exp_r, v}) begin
                failures++;
                $display("FAIL stream[%0d] got c8=%b s=%h vld=%b want %b/%h/%b",
                         i, c8, s, out_valid, exp_r[8], exp_r[7:0], v);
            end
`ifdef ADDER_OVF_EN
            checks++;
            if (ovf !== exp_o) begin
                failures++;
                $display("FAIL stream_ovf[%0d] got %b want %b", i, ovf, exp_o);
            end
`endif
        end
    endtask

    task automatic test_sweep();
        logic [8:0] exp_r;
        logic       ci;
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 256; b++) begin
                ci = 1'($urandom);
                step(1'b1, 8'(a), 8'(b), ci);
                exp_r = ref_sum(8'(a), 8'(b), ci);
                checks++;
                if ({c8, s, out_valid} !== {exp_r, 1'b1}) begin
                    failures++;
                    $display("FAIL sweep %h+%h+%b got c8=%b s=%h vld=%b want %b/%h/1",
                             a[7:0], b[7:0], ci, c8, s, out_valid, exp_r[8], exp_r[7:0]);
                end
`ifdef ADDER_OVF_EN
                checks++;
                if (ovf !== ref_ovf(8'(a), 8'(b), ci)) begin
                    failures++;
                    $display("FAIL sweep_ovf %h+%h+%b got %b", a[7:0], b[7:0], ci, ovf);
                end
`endif
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_back_to_back();
        test_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
